// File: rtl/uart_transmitter.sv
`timescale 1ns/1ps
// uart_transmitter: serialises one DBIT-wide word into a UART frame
//   (start 0, data LSB-first, optional parity, stop 1s), paced by a 16x baud tick.
// Ports: clk/reset_n (async active-low); s_tick 16x oversample tick;
//   tx_start/tx_din request+word (sampled only in idle); tx registered serial line;
//   tx_busy = not idle; tx_done_tick one-clk pulse on the last stop-bit tick.
module uart_transmitter #(
  parameter int DBIT       = 8,
  parameter int SB_TICK    = 16,
  parameter int PARITY_EN  = 0,
  parameter int PARITY_ODD = 0
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic            s_tick,
  input  logic            tx_start,
  input  logic [DBIT-1:0] tx_din,
  output logic            tx,
  output logic            tx_busy,
  output logic            tx_done_tick
);

  localparam int S_W = ($clog2(SB_TICK) > 4) ? $clog2(SB_TICK) : 4;
  localparam int N_W = $clog2(DBIT);

  localparam logic [S_W-1:0] S_ONE       = S_W'(1);
  localparam logic [S_W-1:0] S_BIT_LAST  = S_W'(15);
  localparam logic [S_W-1:0] S_STOP_LAST = S_W'(SB_TICK - 1);
  localparam logic [N_W-1:0] N_ONE       = N_W'(1);
  localparam logic [N_W-1:0] N_LAST      = N_W'(DBIT - 1);
  localparam logic           PAR_INIT    = (PARITY_ODD != 0);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_PARITY,
    ST_STOP
  } state_t;

  state_t          state_q, state_d;
  logic [S_W-1:0]  s_q, s_d;
  logic [N_W-1:0]  n_q, n_d;
  logic [DBIT-1:0] b_q, b_d;
  logic            par_q, par_d;
  logic            tx_q, tx_d;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ST_IDLE;
      s_q     <= '0;
      n_q     <= '0;
      b_q     <= '0;
      par_q   <= 1'b0;
      tx_q    <= 1'b1;
    end else begin
      state_q <= state_d;
      s_q     <= s_d;
      n_q     <= n_d;
      b_q     <= b_d;
      par_q   <= par_d;
      tx_q    <= tx_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    s_d          = s_q;
    n_d          = n_q;
    b_d          = b_q;
    par_d        = par_q;
    tx_done_tick = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (tx_start) begin
          state_d = ST_START;
          s_d     = '0;
          b_d     = tx_din;
          par_d   = PAR_INIT;
        end
      end
      ST_START: begin
        if (s_tick) begin
          if (s_q == S_BIT_LAST) begin
            s_d     = '0;
            n_d     = '0;
            state_d = ST_DATA;
          end else begin
            s_d = s_q + S_ONE;
          end
        end
      end
      ST_DATA: begin
        if (s_tick) begin
          if (s_q == S_BIT_LAST) begin
            s_d   = '0;
            b_d   = b_q >> 1;
            par_d = par_q ^ b_q[0];
            if (n_q == N_LAST) begin
              state_d = (PARITY_EN != 0) ? ST_PARITY : ST_STOP;
            end else begin
              n_d = n_q + N_ONE;
            end
          end else begin
            s_d = s_q + S_ONE;
          end
        end
      end
      ST_PARITY: begin
        if (s_tick) begin
          if (s_q == S_BIT_LAST) begin
            s_d     = '0;
            state_d = ST_STOP;
          end else begin
            s_d = s_q + S_ONE;
          end
        end
      end
      ST_STOP: begin
        if (s_tick) begin
          if (s_q == S_STOP_LAST) begin
            tx_done_tick = 1'b1;
            state_d      = ST_IDLE;
          end else begin
            s_d = s_q + S_ONE;
          end
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // The line level is derived from the next state so the register output
    // lines up with the state: the start bit appears the clk after accept.
    case (state_d)
      ST_START:  tx_d = 1'b0;
      ST_DATA:   tx_d = b_d[0];
      ST_PARITY: tx_d = par_d;
      default:   tx_d = 1'b1;
    endcase
  end

  assign tx      = tx_q;
  assign tx_busy = (state_q != ST_IDLE);

endmodule

// File: tb/tb_uart_transmitter.sv
`timescale 1ns/1ps
module tb_uart_transmitter;

  logic       clk = 1'b0;
  logic       reset_n = 1'b1;
  logic       s_tick = 1'b0;
  logic [7:0] tx_din = 8'h00;
  logic [3:0] start_v = 4'b0000;
  logic [3:0] tx_v, busy_v, done_v;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  // 0: defaults, 1: even parity, 2: odd parity, 3: two stop bits
  uart_transmitter #(.DBIT(8), .SB_TICK(16), .PARITY_EN(0), .PARITY_ODD(0)) u_def (
    .clk(clk), .reset_n(reset_n), .s_tick(s_tick), .tx_start(start_v[0]), .tx_din(tx_din),
    .tx(tx_v[0]), .tx_busy(busy_v[0]), .tx_done_tick(done_v[0]));
  uart_transmitter #(.DBIT(8), .SB_TICK(16), .PARITY_EN(1), .PARITY_ODD(0)) u_even (
    .clk(clk), .reset_n(reset_n), .s_tick(s_tick), .tx_start(start_v[1]), .tx_din(tx_din),
    .tx(tx_v[1]), .tx_busy(busy_v[1]), .tx_done_tick(done_v[1]));
  uart_transmitter #(.DBIT(8), .SB_TICK(16), .PARITY_EN(1), .PARITY_ODD(1)) u_odd (
    .clk(clk), .reset_n(reset_n), .s_tick(s_tick), .tx_start(start_v[2]), .tx_din(tx_din),
    .tx(tx_v[2]), .tx_busy(busy_v[2]), .tx_done_tick(done_v[2]));
  uart_transmitter #(.DBIT(8), .SB_TICK(32), .PARITY_EN(0), .PARITY_ODD(0)) u_sb32 (
    .clk(clk), .reset_n(reset_n), .s_tick(s_tick), .tx_start(start_v[3]), .tx_din(tx_din),
    .tx(tx_v[3]), .tx_busy(busy_v[3]), .tx_done_tick(done_v[3]));

  typedef struct {
    int         inst;       // which instance
    logic [7:0] din;        // word to send
    int         per;        // clks per s_tick
    bit         pe;         // instance has a parity bit
    logic       par;        // hand-computed parity bit
    int         done_j;     // hand-computed clk index (from first start-bit clk) of tx_done_tick
    int         extra_at;   // clk index of an extra tx_start pulse, -1 = none
    logic [7:0] extra_din;  // tx_din after the accept cycle
    int         nfr;        // frames expected
    bit         hold;       // tx_start held high across frames
  } vec_t;

  vec_t vecs[9];

  task automatic check(input string name, input int act, input int exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic run_frame(input vec_t v, input string tag);
    int   t_per, last, f, jj, k, ndone;
    int   tx_bad, busy_bad, done_bad;
    logic etx, ebusy, edone;
    logic tx_ba, busy_ba, done_ba;
    t_per    = v.done_j + 2;
    last     = v.hold ? (v.nfr * t_per - 1) : (v.done_j + 2);
    ndone    = 0;
    tx_bad   = -1;
    busy_bad = -1;
    done_bad = -1;
    tx_ba    = 1'b0;
    busy_ba  = 1'b0;
    done_ba  = 1'b0;
    @(posedge clk); #1;
    start_v         = 4'b0000;
    start_v[v.inst] = 1'b1;
    tx_din          = v.din;
    s_tick          = 1'b0;
    for (int j = 0; j <= last; j++) begin
      @(posedge clk); #1;
      s_tick  = ((j % v.per) == (v.per - 1));
      start_v = 4'b0000;
      if (v.hold) begin
        if (j <= t_per - 1) start_v[v.inst] = 1'b1;
        tx_din = v.din;
      end else begin
        tx_din = v.extra_din;
        if (j == v.extra_at) start_v[v.inst] = 1'b1;
      end
      @(negedge clk);
      if (v.hold) begin
        f  = j / t_per;
        jj = j % t_per;
      end else begin
        f  = (j <= v.done_j) ? 0 : v.nfr;
        jj = j;
      end
      if (f >= v.nfr || jj > v.done_j) begin
        etx = 1'b1; ebusy = 1'b0; edone = 1'b0;
      end else begin
        ebusy = 1'b1;
        edone = (jj == v.done_j);
        k = jj / (16 * v.per);
        if (k == 0)               etx = 1'b0;
        else if (k <= 8)          etx = v.din[k-1];
        else if (k == 9 && v.pe)  etx = v.par;
        else                      etx = 1'b1;
      end
      if (done_v[v.inst] === 1'b1) ndone++;
      if (tx_bad < 0 && tx_v[v.inst] !== etx) begin
        tx_bad = j; tx_ba = tx_v[v.inst];
      end
      if (busy_bad < 0 && busy_v[v.inst] !== ebusy) begin
        busy_bad = j; busy_ba = busy_v[v.inst];
      end
      if (done_bad < 0 && done_v[v.inst] !== edone) begin
        done_bad = j; done_ba = done_v[v.inst];
      end
    end
    @(posedge clk); #1;
    start_v = 4'b0000;
    s_tick  = 1'b0;
    n_tests += 4;
    if (tx_bad >= 0) begin
      n_fail++;
      $display("FAIL %s tx_wave: clk %0d got %b expected %b", tag, tx_bad, tx_ba, ~tx_ba);
    end
    if (busy_bad >= 0) begin
      n_fail++;
      $display("FAIL %s busy_wave: clk %0d got %b expected %b", tag, busy_bad, busy_ba, ~busy_ba);
    end
    if (done_bad >= 0) begin
      n_fail++;
      $display("FAIL %s done_wave: clk %0d got %b expected %b", tag, done_bad, done_ba, ~done_ba);
    end
    if (ndone != v.nfr) begin
      n_fail++;
      $display("FAIL %s done_count: got %0d expected %0d", tag, ndone, v.nfr);
    end
  endtask

  initial begin
    int bad;
    //          inst din    per pe par done  extra xdin   nfr hold
    vecs[0] = '{0, 8'hA5, 1, 0, 0, 159, -1, 8'h5A, 1, 0};
    vecs[1] = '{1, 8'hA5, 1, 1, 0, 175, -1, 8'h5A, 1, 0};
    vecs[2] = '{2, 8'hA5, 1, 1, 1, 175, -1, 8'h5A, 1, 0};
    vecs[3] = '{1, 8'h07, 1, 1, 1, 175, -1, 8'hF8, 1, 0};
    vecs[4] = '{0, 8'hA5, 1, 0, 0, 159, 40, 8'h3C, 1, 0};
    vecs[5] = '{3, 8'h00, 4, 0, 0, 703, -1, 8'hFF, 1, 0};
    vecs[6] = '{0, 8'h55, 1, 0, 0, 159, -1, 8'h55, 2, 1};
    vecs[7] = '{2, 8'h07, 1, 1, 0, 175, -1, 8'hF8, 1, 0};
    vecs[8] = '{0, 8'hFF, 1, 0, 0, 159, -1, 8'h00, 1, 0};

    // asynchronous reset takes effect before any clock edge
    #1 reset_n = 1'b0;
    #2;
    check("rst_tx",   int'(tx_v),   15);
    check("rst_busy", int'(busy_v), 0);
    check("rst_done", int'(done_v), 0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    check("idle_tx", int'(tx_v), 15);

    for (int i = 0; i < 8; i++) begin
      run_frame(vecs[i], $sformatf("v%0d", i));
    end

    // abort during data bit 3 of 0xA5 (bit 3 = 0), after a stalled s_tick
    @(posedge clk); #1;
    start_v = 4'b0001; tx_din = 8'hA5; s_tick = 1'b0;
    for (int j = 0; j <= 68; j++) begin
      @(posedge clk); #1;
      start_v = 4'b0000; tx_din = 8'h3C; s_tick = 1'b1;
    end
    @(negedge clk);
    check("abort_pre_bit3", int'(tx_v[0]), 0);
    bad = 0;
    for (int j = 0; j < 20; j++) begin
      @(posedge clk); #1;
      s_tick = 1'b0;
      @(negedge clk);
      if (tx_v[0] !== 1'b0 || busy_v[0] !== 1'b1) bad++;
    end
    check("stall_hold", bad, 0);
    #2 reset_n = 1'b0;
    #1;
    check("abort_tx",   int'(tx_v[0]),   1);
    check("abort_busy", int'(busy_v[0]), 0);
    check("abort_done", int'(done_v[0]), 0);
    bad = 0;
    for (int j = 0; j < 3; j++) begin
      @(posedge clk); #1;
      s_tick = 1'b1;
      @(negedge clk);
      if (done_v[0] !== 1'b0 || tx_v[0] !== 1'b1) bad++;
    end
    check("abort_quiet", bad, 0);
    reset_n = 1'b1;
    s_tick  = 1'b0;
    run_frame(vecs[8], "after_reset");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
